wb_stage: RTL and testbench

//   Writeback stage of the 3-stage RV32I core. It sits directly upstream of the register file
//   and drives that file's write port (we/rd/wd).
//   It registers the execute result and waits for dmem read data on loads.
//   It aligns and sign-extends load data, selects the writeback source, and returns a

---
 rtl/wb_stage_pkg.sv | 27 ++
 rtl/wb_stage_load_align.sv | 49 ++++
 rtl/wb_stage.sv | 135 +++++++++++++
 tb/tb_wb_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the writeback stage: writeback source
// select codes, load funct3 codes and the stage's FSM state encoding.
package wb_stage_pkg;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'd0,
    WB_SEL_LOAD = 2'd1,
    WB_SEL_PC4  = 2'd2,
    WB_SEL_CSR  = 2'd3
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_LWAIT = 2'd2
  } wb_state_e;

  // Width of the load-timeout counter.
  localparam int TMO_W = 4;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load alignment: picks the byte/half/word out of a word-aligned dmem read
// using the captured byte offset and sign- or zero-extends it to XLEN.
module wb_stage_load_align
  import wb_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  function automatic logic [XLEN-1:0] ext_byte(input logic [7:0] b, input logic is_signed);
    logic signed [7:0]      bs;
    logic signed [XLEN-1:0] wide;
    bs   = signed'(b);
    wide = bs;
    return is_signed ? wide : XLEN'(b);
  endfunction

  function automatic logic [XLEN-1:0] ext_half(input logic [15:0] h, input logic is_signed);
    logic signed [15:0]     hs;
    logic signed [XLEN-1:0] wide;
    hs   = signed'(h);
    wide = hs;
    return is_signed ? wide : XLEN'(h);
  endfunction

  assign byte_sel = rdata[{off, 3'b000} +: 8];
  // Halfword loads ignore off[0]: the half is chosen by off[1] only.
  assign half_sel = rdata[{off[1], 4'b0000} +: 16];

  // Size/sign decode; reserved funct3 codes fall back to a full word.
  always_comb begin
    result = rdata;
    case (funct3)
      F3_LB:   result = ext_byte(byte_sel, 1'b1);
      F3_LBU:  result = ext_byte(byte_sel, 1'b0);
      F3_LH:   result = ext_half(half_sel, 1'b1);
      F3_LHU:  result = ext_half(half_sel, 1'b0);
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage of the 3-stage RV32I core. Holds one instruction from
// execute, waits for dmem data on loads, drives the register-file write port
// and returns a same-cycle bypass plus a stall to execute.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int RF_AW        = 5,
  parameter int LOAD_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [RF_AW-1:0] ex_rd,
  input  logic             ex_rd_we,
  input  logic [1:0]       ex_wb_sel,
  input  logic [XLEN-1:0]  ex_alu,
  input  logic [XLEN-1:0]  ex_pc4,
  input  logic [XLEN-1:0]  ex_csr,
  input  logic [2:0]       ex_funct3,
  input  logic             dmem_rvalid,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             wb_stall,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_rd,
  output logic [XLEN-1:0]  rf_wd,
  output logic             fwd_valid,
  output logic [RF_AW-1:0] fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic             load_err
);

  // Counter value seen in the last LWAIT cycle before the load is dropped.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOAD_TIMEOUT - 1);

  wb_state_e        state;
  logic [TMO_W-1:0] wait_cnt;

  logic [RF_AW-1:0] rd_p1;
  logic             rd_we_p1;
  logic [2:0]       funct3_p1;
  logic [1:0]       off_p1;
  logic [XLEN-1:0]  val_p1;

  wb_sel_e          sel;
  logic [XLEN-1:0]  sel_val;
  logic [XLEN-1:0]  load_data;
  logic             accept;
  logic             writes_rd;
  logic             commit;

  assign sel       = wb_sel_e'(ex_wb_sel);
  assign writes_rd = rd_we_p1 && (rd_p1 != '0);
  assign wb_stall  = (state == ST_LWAIT) && !dmem_rvalid;
  assign accept    = ex_valid && !wb_stall;

  wb_stage_load_align #(
    .XLEN(XLEN)
  ) u_align (
    .funct3(funct3_p1),
    .off   (off_p1),
    .rdata (dmem_rdata),
    .result(load_data)
  );

  // Non-load writeback value chosen at accept time so only one word is held.
  always_comb begin
    sel_val = ex_alu;
    case (sel)
      WB_SEL_PC4: sel_val = ex_pc4;
      WB_SEL_CSR: sel_val = ex_csr;
      default:    sel_val = ex_alu;
    endcase
  end

  // Write-port decode from state; write data is zeroed when nothing commits.
  always_comb begin
    commit = 1'b0;
    case (state)
      ST_HOLD:  commit = writes_rd;
      ST_LWAIT: commit = writes_rd && dmem_rvalid;
      default:  commit = 1'b0;
    endcase
    rf_we = commit;
    rf_rd = commit ? rd_p1 : '0;
    rf_wd = '0;
    if (commit) begin
      rf_wd = (state == ST_LWAIT) ? load_data : val_p1;
    end
  end

  assign fwd_valid = rf_we;
  assign fwd_rd    = rf_rd;
  assign fwd_data  = rf_wd;

  // FSM: occupancy, load-timeout counter and sticky load error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      load_err <= 1'b0;
    end else if (accept) begin
      state    <= (sel == WB_SEL_LOAD) ? ST_LWAIT : ST_HOLD;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_HOLD: state <= ST_IDLE;
        ST_LWAIT: begin
          if (dmem_rvalid) begin
            state <= ST_IDLE;
          end else if (wait_cnt == TMO_LAST) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            load_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---- p1: captured instruction fields (data path, not reset) ----
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_p1     <= ex_rd;
      rd_we_p1  <= ex_rd_we;
      funct3_p1 <= ex_funct3;
      off_p1    <= ex_alu[1:0];
      val_p1    <= sel_val;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios followed by randomized traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_rd_we;
  logic [1:0]  ex_wb_sel;
  logic [31:0] ex_alu;
  logic [31:0] ex_pc4;
  logic [31:0] ex_csr;
  logic [2:0]  ex_funct3;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_stall;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        load_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_rd      (ex_rd),
    .ex_rd_we   (ex_rd_we),
    .ex_wb_sel  (ex_wb_sel),
    .ex_alu     (ex_alu),
    .ex_pc4     (ex_pc4),
    .ex_csr     (ex_csr),
    .ex_funct3  (ex_funct3),
    .dmem_rvalid(dmem_rvalid),
    .dmem_rdata (dmem_rdata),
    .wb_stall   (wb_stall),
    .rf_we      (rf_we),
    .rf_rd      (rf_rd),
    .rf_wd      (rf_wd),
    .fwd_valid  (fwd_valid),
    .fwd_rd     (fwd_rd),
    .fwd_data   (fwd_data),
    .load_err   (load_err)
  );

  // Reference model: the one instruction held by writeback, if any.
  bit          m_held;
  bit          m_is_load;
  logic [4:0]  m_rd;
  bit          m_we;
  logic [31:0] m_val;
  logic [2:0]  m_f3;
  logic [1:0]  m_off;
  int          m_waited;
  bit          m_err;
  bit          after_rst;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Load result computed arithmetically from the size/sign rules.
  function automatic logic [31:0] ref_align(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] d);
    longint w;
    longint v;
    w = longint'(d);
    case (f3)
      3'b000, 3'b100: begin
        v = (w >> (8 * int'(off))) % 256;
        if (f3 == 3'b000 && v >= 128) v = v - 256;
      end
      3'b001, 3'b101: begin
        v = (w >> (16 * (int'(off) / 2))) % 65536;
        if (f3 == 3'b001 && v >= 32768) v = v - 65536;
      end
      default: v = w;
    endcase
    return v[31:0];
  endfunction

  // Compare outputs at the negedge, then advance the model across the next posedge.
  task automatic step();
    bit          e_stall;
    bit          e_we;
    logic [31:0] e_wd;
    bit          acc;
    @(negedge clk);
    e_stall = m_held && m_is_load && !dmem_rvalid;
    e_we    = 1'b0;
    e_wd    = 32'h0;
    if (m_held && !m_is_load) begin
      e_we = m_we && (m_rd != 5'd0);
      e_wd = m_val;
    end else if (m_held && m_is_load && dmem_rvalid) begin
      e_we = m_we && (m_rd != 5'd0);
      e_wd = ref_align(m_f3, m_off, dmem_rdata);
    end
    check("wb_stall", 32'(wb_stall), 32'(e_stall));
    check("rf_we", 32'(rf_we), 32'(e_we));
    check("fwd_valid", 32'(fwd_valid), 32'(e_we));
    check("load_err", 32'(load_err), 32'(m_err));
    if (e_we) begin
      check("rf_rd", 32'(rf_rd), 32'(m_rd));
      check("rf_wd", rf_wd, e_wd);
      check("fwd_rd", 32'(fwd_rd), 32'(m_rd));
      check("fwd_data", fwd_data, e_wd);
    end
    if (after_rst) begin
      check("rst_rf_rd", 32'(rf_rd), 32'h0);
      check("rst_rf_wd", rf_wd, 32'h0);
      check("rst_fwd_rd", 32'(fwd_rd), 32'h0);
      check("rst_fwd_data", fwd_data, 32'h0);
    end
    acc       = ex_valid && !e_stall;
    after_rst = rst;
    if (rst) begin
      m_held = 1'b0;
      m_err  = 1'b0;
    end else if (acc) begin
      m_held    = 1'b1;
      m_is_load = (ex_wb_sel == 2'd1);
      m_rd      = ex_rd;
      m_we      = ex_rd_we;
      m_f3      = ex_funct3;
      m_off     = ex_alu[1:0];
      m_waited  = 0;
      case (ex_wb_sel)
        2'd2:    m_val = ex_pc4;
        2'd3:    m_val = ex_csr;
        default: m_val = ex_alu;
      endcase
    end else if (m_held && !m_is_load) begin
      m_held = 1'b0;
    end else if (m_held && m_is_load) begin
      if (dmem_rvalid) begin
        m_held = 1'b0;
      end else begin
        m_waited++;
        if (m_waited == 15) begin
          m_held = 1'b0;
          m_err  = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit v, input logic [4:0] rd, input bit we, input logic [1:0] sel,
                     input logic [31:0] alu, input logic [2:0] f3, input bit rv,
                     input logic [31:0] rdat);
    ex_valid    = v;
    ex_rd       = rd;
    ex_rd_we    = we;
    ex_wb_sel   = sel;
    ex_alu      = alu;
    ex_pc4      = $urandom;
    ex_csr      = $urandom;
    ex_funct3   = f3;
    dmem_rvalid = rv;
    dmem_rdata  = rdat;
  endtask

  task automatic idle(input bit rv, input logic [31:0] rdat);
    drv(1'b0, 5'd0, 1'b0, 2'd0, 32'h0, 3'b0, rv, rdat);
  endtask

  initial begin
    int p_rv;
    m_held    = 1'b0;
    m_err     = 1'b0;
    after_rst = 1'b0;
    rst       = 1'b1;
    idle(1'b0, 32'h0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;

    // ALU writeback to x5
    drv(1'b1, 5'd5, 1'b1, 2'd0, 32'h0000_1234, 3'b0, 1'b0, 32'h0);
    step();
    idle(1'b0, 32'h0);
    step();

    // LB at offset 3, data two cycles late
    drv(1'b1, 5'd7, 1'b1, 2'd1, 32'h0000_1003, 3'b000, 1'b0, 32'h0);
    step();
    idle(1'b0, 32'h0);
    step();
    step();
    idle(1'b1, 32'h80FF_0000);
    step();
    idle(1'b0, 32'h0);
    step();

    // LHU at offset 2, data the next cycle
    drv(1'b1, 5'd9, 1'b1, 2'd1, 32'h0000_2002, 3'b101, 1'b0, 32'h0);
    step();
    idle(1'b1, 32'h8001_0000);
    step();

    // x0 destination for every writeback source
    for (int s = 0; s < 4; s++) begin
      drv(1'b1, 5'd0, 1'b1, 2'(s), $urandom, 3'b010, 1'b0, 32'h0);
      step();
      idle(1'b1, $urandom);
      step();
    end

    // Load completes while an ALU op waits: accepted in the rvalid cycle
    drv(1'b1, 5'd3, 1'b1, 2'd1, 32'h0000_0000, 3'b010, 1'b0, 32'h0);
    step();
    drv(1'b1, 5'd4, 1'b1, 2'd0, 32'hCAFE_0004, 3'b0, 1'b1, 32'hDEAD_BEEF);
    step();
    idle(1'b0, 32'h0);
    step();

    // Timeout: 15 LWAIT cycles without rvalid, then sticky load_err
    drv(1'b1, 5'd6, 1'b1, 2'd1, 32'h0, 3'b010, 1'b0, 32'h0);
    step();
    idle(1'b0, 32'h0);
    for (int i = 0; i < 17; i++) step();
    idle(1'b1, 32'h1234_5678);
    step();

    // Reset during LWAIT abandons the load
    drv(1'b1, 5'd8, 1'b1, 2'd1, 32'h0, 3'b010, 1'b0, 32'h0);
    step();
    idle(1'b0, 32'h0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(1'b1, 32'hFFFF_FFFF);
    step();
    step();

    // Randomized traffic with phases of reliable and very slow dmem
    for (int c = 0; c < 3000; c++) begin
      p_rv = ((c / 500) % 2 == 0) ? 45 : 3;
      drv(($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0,
          ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
          ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
          2'($urandom),
          $urandom,
          3'($urandom),
          ($urandom_range(0, 99) < p_rv) ? 1'b1 : 1'b0,
          $urandom);
      rst = ($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0;
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
